pixel_readout: RTL and testbench

PIXEL_READOUT -- requirements
Module: pixel_readout

---
 rtl/pixel_readout.sv | 244 ++++++++++++++++++++++++
 tb/tb_pixel_readout.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout.sv
`default_nettype none
// ============================================================================
// Module      : pixel_readout
// Description : Captures one 4-pixel frame per readout phase of a pixel
//               array, queues it (with an 8-bit frame tag) in a small FIFO
//               and serializes each queued frame as four bytes over a
//               valid/ready stream. Frames arriving while the FIFO is full
//               are dropped and counted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH       FIFO depth in 32-bit frame words (power of two, >= 2)
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-high reset
//   read        readout-phase strobe; a capture happens on its rising edge
//   pixData1..4 pixel value buses, valid while read = 1
//   out_data    serialized pixel byte (pixel 1 first)
//   out_valid   out_data / out_first / out_last / out_frame are valid
//   out_ready   downstream accepts the byte when out_valid & out_ready
//   out_first   byte is pixel 1 of its frame
//   out_last    byte is pixel 4 of its frame
//   out_frame   tag of the frame currently being sent
//   overflow    sticky flag: at least one frame dropped since reset
//   drop_count  number of dropped frames, saturating at 255
// ============================================================================
module pixel_readout #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    input  logic [7:0] pixData1,
    input  logic [7:0] pixData2,
    input  logic [7:0] pixData3,
    input  logic [7:0] pixData4,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_first,
    output logic       out_last,
    output logic [7:0] out_frame,
    output logic       overflow,
    output logic [7:0] drop_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_ENTRY_W  = 40;   // {tag[7:0], pixels[31:0]}
    localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(DEPTH);

    localparam logic [0:0]      c_ST_IDLE  = 1'b0;
    localparam logic [0:0]      c_ST_SEND  = 1'b1;

    localparam logic [1:0]      c_IDX_LAST = 2'd3;
    localparam logic [7:0]      c_DROP_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // Capture detection
    // ------------------------------------------------------------------------
    // r_read_d comes out of reset high so that a read strobe that is already
    // asserted when reset is released is not mistaken for a new phase.
    logic r_read_d;
    logic w_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_d <= 1'b1;
        end else begin
            r_read_d <= read;
        end
    end

    assign w_capture = read & ~r_read_d;

    // ------------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_ADDR_W:0]    r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_ENTRY_W-1:0] w_wr_entry;

    logic [7:0]           r_tag_cnt;

    // Full is judged on the occupancy before the edge: a pop at the same
    // edge does not make room for a capture.
    assign w_full     = (r_count == c_FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = w_capture & ~w_full;
    assign w_drop     = w_capture &  w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_wr_entry = {r_tag_cnt, pixData4, pixData3, pixData2, pixData1};

    // Storage needs no reset: entries are only ever read when r_count says
    // they were written since the last reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame tag and drop statistics
    // ------------------------------------------------------------------------
    logic       r_overflow;
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_cnt  <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_tag_cnt <= r_tag_cnt + 8'd1;   // wraps 255 -> 0
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_DROP_MAX) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

    // ------------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic [7:0]  r_tag;

    logic        w_send;
    logic        w_accept;
    logic        w_frame_done;

    assign w_send       = (r_state == c_ST_SEND);
    assign w_accept     = w_send & out_ready;
    assign w_frame_done = w_accept & (r_idx == c_IDX_LAST);

    // A new word is taken from the FIFO either from IDLE, or in the same
    // cycle the last byte of the current frame is accepted so that
    // consecutive frames stream without a bubble.
    assign w_pop = ~w_empty & (~w_send | w_frame_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_ST_SEND;
                        r_idx   <= '0;
                        r_word  <= w_head[31:0];
                        r_tag   <= w_head[39:32];
                    end
                end
                c_ST_SEND: begin
                    if (w_accept) begin
                        if (r_idx != c_IDX_LAST) begin
                            r_idx <= r_idx + 2'd1;
                        end else if (w_pop) begin
                            r_idx  <= '0;
                            r_word <= w_head[31:0];
                            r_tag  <= w_head[39:32];
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_idx   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // Outputs are a pure decode of serializer registers, so they stay stable
    // while out_ready is low and read as zero whenever nothing is being sent.
    logic [7:0] w_byte;

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            default: w_byte = r_word[31:24];
        endcase
    end

    assign out_valid = w_send;
    assign out_data  = w_send ? w_byte : 8'h00;
    assign out_frame = w_send ? r_tag  : 8'h00;
    assign out_first = w_send & (r_idx == 2'd0);
    assign out_last  = w_send & (r_idx == c_IDX_LAST);

endmodule

`default_nettype wire

// File: tb/tb_pixel_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_readout
// Description : Self-checking bench for pixel_readout (DEPTH = 4). A table of
//               per-cycle vectors covers single and back-to-back frames;
//               hand-written sequences cover backpressure, overflow, tag wrap,
//               drop-count saturation and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_readout;

    logic       clk;
    logic       reset;
    logic       read;
    logic [7:0] pix1, pix2, pix3, pix4;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;
    logic [7:0] out_frame;
    logic       overflow;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    pixel_readout #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .pixData1   (pix1),
        .pixData2   (pix2),
        .pixData3   (pix3),
        .pixData4   (pix4),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_frame  (out_frame),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic [7:0] p1, p2, p3, p4;
        logic       rdy;
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       l;
        logic [7:0] fr;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic rd, input logic [7:0] p1, input logic [7:0] p2,
                                input logic [7:0] p3, input logic [7:0] p4, input logic rdy,
                                input logic v, input logic [7:0] d, input logic f,
                                input logic l, input logic [7:0] fr);
        vec_t t;
        t.rd = rd; t.p1 = p1; t.p2 = p2; t.p3 = p3; t.p4 = p4; t.rdy = rdy;
        t.v = v; t.d = d; t.f = f; t.l = l; t.fr = fr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        pix1 = a; pix2 = b; pix3 = c; pix4 = d;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] d,
                           input logic f, input logic l, input logic [7:0] fr);
        chk({name, " valid"}, 32'(out_valid), 32'(v));
        chk({name, " data"},  32'(out_data),  32'(d));
        chk({name, " first"}, 32'(out_first), 32'(f));
        chk({name, " last"},  32'(out_last),  32'(l));
        chk({name, " frame"}, 32'(out_frame), 32'(fr));
    endtask

    // Reset, then one idle cycle with read low so the next read high is a
    // genuine rising edge.
    task automatic do_reset();
        reset = 1'b1;
        read  = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int exp_tag;
        logic [7:0] e;

        reset = 1'b1; read = 1'b0; out_ready = 1'b0;
        set_pix(8'h00, 8'h00, 8'h00, 8'h00);

        // ---------------- reset state ----------------
        step();
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset drop_count", 32'(drop_count), 32'd0);
        step();
        reset = 1'b0;

        // ---------------- table: single frame, then back-to-back frames -----
        vecs[0]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
        vecs[1]  = mk(1, 8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 8'h00, 0, 0, 8'h00);
        vecs[2]  = mk(1, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1, 8'h11, 1, 0, 8'h00);
        vecs[3]  = mk(1, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1, 8'h22, 0, 0, 8'h00);
        vecs[4]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h33, 0, 0, 8'h00);
        vecs[5]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h44, 0, 1, 8'h00);
        vecs[6]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
        vecs[7]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);
        vecs[8]  = mk(1, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 0, 8'h00, 0, 0, 8'h00);
        vecs[9]  = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA1, 1, 0, 8'h01);
        vecs[10] = mk(1, 8'h55, 8'h66, 8'h77, 8'h88, 1, 1, 8'hB2, 0, 0, 8'h01);
        vecs[11] = mk(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 8'hC3, 0, 0, 8'h01);
        vecs[12] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hD4, 0, 1, 8'h01);
        vecs[13] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h55, 1, 0, 8'h02);
        vecs[14] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h66, 0, 0, 8'h02);
        vecs[15] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h77, 0, 0, 8'h02);
        vecs[16] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h88, 0, 1, 8'h02);
        vecs[17] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00);

        for (int i = 0; i < 18; i++) begin
            read = vecs[i].rd;
            set_pix(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].p4);
            out_ready = vecs[i].rdy;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].f,
                    vecs[i].l, vecs[i].fr);
        end

        // ---------------- backpressure mid-frame (tag 3) ----------------
        set_pix(8'h01, 8'h02, 8'h03, 8'h04);
        read = 1'b1; out_ready = 1'b1; step();
        chk_out("bp cap", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        read = 1'b0; step();
        chk_out("bp b0", 1'b1, 8'h01, 1'b1, 1'b0, 8'h03);
        step();
        chk_out("bp b1", 1'b1, 8'h02, 1'b0, 1'b0, 8'h03);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("bp hold%0d", i), 1'b1, 8'h02, 1'b0, 1'b0, 8'h03);
        end
        out_ready = 1'b1; step();
        chk_out("bp b2", 1'b1, 8'h03, 1'b0, 1'b0, 8'h03);
        step();
        chk_out("bp b3", 1'b1, 8'h04, 1'b0, 1'b1, 8'h03);
        step();
        chk_out("bp idle", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // ---------------- overflow with DEPTH=4 ----------------
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) set_pix(8'(k*16+1), 8'(k*16+2), 8'(k*16+3), 8'(k*16+4));
            else       set_pix(8'hE1, 8'hE2, 8'hE3, 8'hE4);
            read = 1'b1; step();
            read = 1'b0; step();
            if (k == 4) chk("ovf before drop", 32'(overflow), 32'd0);
        end
        chk("ovf flag", 32'(overflow), 32'd1);
        chk("ovf drop_count", 32'(drop_count), 32'd1);

        // Drain. A capture during the last byte of frame 0 meets a full FIFO
        // with a simultaneous pop and must be dropped; a capture during the
        // last byte of frame 2 is accepted as tag 5 alongside a pop.
        out_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 4; b++) begin
                chk_out($sformatf("drain f%0d b%0d", f, b), 1'b1, 8'(f*16+b+1),
                        (b == 0), (b == 3), 8'(f));
                if (f == 0 && b == 3) begin
                    set_pix(8'hEE, 8'hEE, 8'hEE, 8'hEE);
                    read = 1'b1;
                end else if (f == 2 && b == 3) begin
                    set_pix(8'h51, 8'h52, 8'h53, 8'h54);
                    read = 1'b1;
                end else begin
                    read = 1'b0;
                end
                step();
            end
        end
        chk_out("drain end", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("drain overflow", 32'(overflow), 32'd1);
        chk("drain drop_count", 32'(drop_count), 32'd2);

        // ---------------- tag wrap over 300 frames ----------------
        do_reset();
        out_ready = 1'b1;
        exp_tag = 0;
        for (int k = 0; k < 300; k++) begin
            set_pix(8'(k), 8'(k+1), 8'(k+2), 8'(k+3));
            for (int c = 0; c < 5; c++) begin
                read = (c == 0);
                step();
                if (out_valid && out_first) begin
                    chk($sformatf("wrap tag%0d", exp_tag), 32'(out_frame), 32'(exp_tag % 256));
                    exp_tag++;
                end
            end
        end
        read = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid && out_first) begin
                chk($sformatf("wrap tag%0d", exp_tag), 32'(out_frame), 32'(exp_tag % 256));
                exp_tag++;
            end
        end
        chk("wrap frames seen", 32'(exp_tag), 32'd300);
        chk("wrap drop_count", 32'(drop_count), 32'd0);

        // ---------------- drop_count saturation ----------------
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            read = 1'b1; step();
            read = 1'b0; step();
            // 5 accepted (1 in serializer + 4 queued), every later one dropped
            if (k == 258) chk("sat 254", 32'(drop_count), 32'd254);
            if (k == 259) chk("sat 255", 32'(drop_count), 32'd255);
        end
        chk("sat final", 32'(drop_count), 32'd255);
        chk("sat overflow", 32'(overflow), 32'd1);

        // ---------------- reset mid-frame with read held ----------------
        do_reset();
        out_ready = 1'b1;
        set_pix(8'h91, 8'h92, 8'h93, 8'h94);
        read = 1'b1; step();
        read = 1'b0; step();
        chk_out("rst f0b0", 1'b1, 8'h91, 1'b1, 1'b0, 8'h00);
        set_pix(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        read = 1'b1; step();
        chk_out("rst f0b1", 1'b1, 8'h92, 1'b0, 1'b0, 8'h00);
        reset = 1'b1; step();
        chk_out("rst asserted", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("rst held%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        end
        read = 1'b0; step();
        set_pix(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        read = 1'b1; step();
        read = 1'b0; step();
        chk_out("rst new frame", 1'b1, 8'hC1, 1'b1, 1'b0, 8'h00);
        e = 8'hC2;
        step();
        chk_out("rst new b1", 1'b1, e, 1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
